// File: rtl/mem_stage_pkg.sv
// Shared constants for the MEM pipeline stage: op encodings, latch field widths,
// FSM state type and small op-classification helpers.
package mem_stage_pkg;

   localparam int INST_BITS   = 32;
   localparam int OP_BITS     = 6;
   localparam int ICNT_BITS   = 16;
   localparam int REG_BITS    = 5;
   localparam int CANARY_BITS = 4;

   localparam logic [OP_BITS-1:0] OP_ADD = 6'd1;
   localparam logic [OP_BITS-1:0] OP_LB  = 6'd16;
   localparam logic [OP_BITS-1:0] OP_LH  = 6'd17;
   localparam logic [OP_BITS-1:0] OP_LW  = 6'd18;
   localparam logic [OP_BITS-1:0] OP_LBU = 6'd19;
   localparam logic [OP_BITS-1:0] OP_LHU = 6'd20;
   localparam logic [OP_BITS-1:0] OP_SB  = 6'd24;
   localparam logic [OP_BITS-1:0] OP_SH  = 6'd25;
   localparam logic [OP_BITS-1:0] OP_SW  = 6'd26;

   localparam int TO_DE_WIDTH = 1 + REG_BITS + ICNT_BITS;

   typedef enum logic [0:0] {ST_IDLE, ST_REQ} state_e;

   // Head = {valid, inst, PC, op_I, inst_count, rd, wr_reg}, common to both latches
   function automatic int latch_head_width(input int dbits);
      return 1 + INST_BITS + dbits + OP_BITS + ICNT_BITS + REG_BITS + 1;
   endfunction

   function automatic int agex_latch_width(input int dbits);
      return latch_head_width(dbits) + dbits + dbits + CANARY_BITS;
   endfunction

   function automatic int mem_latch_width(input int dbits);
      return latch_head_width(dbits) + dbits + CANARY_BITS;
   endfunction

   function automatic int to_agex_width(input int dbits);
      return 2 + REG_BITS + dbits;
   endfunction

   function automatic logic is_load(input logic [OP_BITS-1:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_store(input logic [OP_BITS-1:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_misaligned(input logic [OP_BITS-1:0] op, input logic [1:0] addr_lo);
      logic half_op;
      logic word_op;
      half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
      word_op = (op == OP_LW) || (op == OP_SW);
      return (half_op && addr_lo[0]) || (word_op && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and memory (slave).
interface mem_stage_if #(
   parameter int DBITS = 32
);
   logic             req;
   logic             we;
   logic [DBITS-1:0] addr;
   logic [DBITS-1:0] wdata;
   logic [3:0]       be;
   logic             ack;
   logic [DBITS-1:0] rdata;

   modport master (output req, we, addr, wdata, be, input ack, rdata);
   modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_stage_align.sv
// mem_align: load byte/halfword extraction with sign/zero extension, and store
// lane replication with byte-enable generation. Purely combinational.
module mem_align
   import mem_stage_pkg::*;
#(
   parameter int DBITS = 32
) (
   input  logic [OP_BITS-1:0] op,
   input  logic [1:0]         addr_lo,
   input  logic [DBITS-1:0]   store_data,
   input  logic [DBITS-1:0]   rdata,
   output logic [3:0]         be,
   output logic [DBITS-1:0]   wdata,
   output logic [DBITS-1:0]   load_data
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;
   logic [3:0]  half_be;

   always_comb begin
      case (addr_lo)
         2'd1:    rbyte = rdata[15:8];
         2'd2:    rbyte = rdata[23:16];
         2'd3:    rbyte = rdata[31:24];
         default: rbyte = rdata[7:0];
      endcase
      rhalf   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      half_be = addr_lo[1] ? 4'b1100 : 4'b0011;

      be        = 4'b0000;
      wdata     = '0;
      load_data = '0;
      case (op)
         OP_LB: begin
            be        = 4'b0001 << addr_lo;
            load_data = {{(DBITS-8){rbyte[7]}}, rbyte};
         end
         OP_LBU: begin
            be        = 4'b0001 << addr_lo;
            load_data = {{(DBITS-8){1'b0}}, rbyte};
         end
         OP_LH: begin
            be        = half_be;
            load_data = {{(DBITS-16){rhalf[15]}}, rhalf};
         end
         OP_LHU: begin
            be        = half_be;
            load_data = {{(DBITS-16){1'b0}}, rhalf};
         end
         OP_LW: begin
            be        = 4'b1111;
            load_data = rdata;
         end
         OP_SB: begin
            be    = 4'b0001 << addr_lo;
            wdata = {(DBITS/8){store_data[7:0]}};
         end
         OP_SH: begin
            be    = half_be;
            wdata = {(DBITS/16){store_data[15:0]}};
         end
         OP_SW: begin
            be    = 4'b1111;
            wdata = store_data;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results through, and runs loads/stores over a
// req/ack data-memory bus with stall, forwarding, timeout and misalignment handling.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DBITS        = 32,
   parameter int DMEM_TIMEOUT = 255,
   localparam int AGEX_W      = agex_latch_width(DBITS),
   localparam int MEM_W       = mem_latch_width(DBITS),
   localparam int TO_AGEX_W   = to_agex_width(DBITS),
   localparam int TO_DE_W     = TO_DE_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [AGEX_W-1:0]    from_AGEX_latch,
   output logic [MEM_W-1:0]     MEM_latch_out,
   output logic [TO_AGEX_W-1:0] from_MEM_to_AGEX,
   output logic [TO_DE_W-1:0]   from_MEM_to_DE,
   mem_stage_if.master          dmem,
   output logic                 mem_err
);

   localparam int HEAD_W     = latch_head_width(DBITS);
   localparam int TW         = $clog2(DMEM_TIMEOUT + 1);
   localparam int RES_LSB    = CANARY_BITS + DBITS;
   localparam int HEAD_LSB   = CANARY_BITS + 2 * DBITS;
   localparam int OP_IN_HEAD = 1 + REG_BITS + ICNT_BITS;
   localparam int WB_LSB     = CANARY_BITS;
   localparam int WR_BIT     = CANARY_BITS + DBITS;
   localparam int RD_LSB     = WR_BIT + 1;
   localparam int ICNT_LSB   = RD_LSB + REG_BITS;

   state_e            state;
   logic              req_q;
   logic [TW-1:0]     tcount;
   logic [AGEX_W-1:0] hold_q;
   logic [MEM_W-1:0]  mem_q;

   logic [HEAD_W-1:0]      a_head;
   logic [OP_BITS-1:0]     a_op;
   logic [DBITS-1:0]       a_result;
   logic [CANARY_BITS-1:0] a_canary;
   logic                   a_valid;
   logic [HEAD_W-1:0]      h_head;
   logic [OP_BITS-1:0]     h_op;
   logic [DBITS-1:0]       h_addr;
   logic [DBITS-1:0]       h_sdata;
   logic [CANARY_BITS-1:0] h_canary;
   logic                   h_store;
   logic                   h_wr;
   logic [DBITS-1:0]       h_wb;

   logic a_mem;
   logic a_bad;
   logic start;
   logic timed_out;
   logic mem_stall;

   logic [3:0]       al_be;
   logic [DBITS-1:0] al_wdata;
   logic [DBITS-1:0] al_load;

   assign a_head   = from_AGEX_latch[HEAD_LSB +: HEAD_W];
   assign a_result = from_AGEX_latch[RES_LSB +: DBITS];
   assign a_canary = from_AGEX_latch[CANARY_BITS-1:0];
   assign a_valid  = a_head[HEAD_W-1];
   assign a_op     = a_head[OP_IN_HEAD +: OP_BITS];

   assign h_head   = hold_q[HEAD_LSB +: HEAD_W];
   assign h_addr   = hold_q[RES_LSB +: DBITS];
   assign h_sdata  = hold_q[CANARY_BITS +: DBITS];
   assign h_canary = hold_q[CANARY_BITS-1:0];
   assign h_op     = h_head[OP_IN_HEAD +: OP_BITS];
   assign h_store  = is_store(h_op);
   assign h_wr     = h_store ? 1'b0 : h_head[0];
   assign h_wb     = h_store ? '0 : al_load;

   // Misaligned memory ops never start a request, so they also never stall.
   assign a_mem     = a_valid && (is_load(a_op) || is_store(a_op));
   assign a_bad     = a_mem && is_misaligned(a_op, a_result[1:0]);
   assign start     = (state == ST_IDLE) && a_mem && !a_bad;
   assign timed_out = (state == ST_REQ) && !dmem.ack && (tcount == TW'(DMEM_TIMEOUT - 1));
   assign mem_stall = start || ((state == ST_REQ) && !dmem.ack);

   mem_align #(.DBITS(DBITS)) u_align (
      .op         (h_op),
      .addr_lo    (h_addr[1:0]),
      .store_data (h_sdata),
      .rdata      (dmem.rdata),
      .be         (al_be),
      .wdata      (al_wdata),
      .load_data  (al_load)
   );

   // The latch defaults to a bubble every cycle; only completed ops override it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         req_q   <= 1'b0;
         tcount  <= '0;
         hold_q  <= '0;
         mem_q   <= '0;
         mem_err <= 1'b0;
      end else begin
         mem_q <= '0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  hold_q <= from_AGEX_latch;
                  tcount <= '0;
                  req_q  <= 1'b1;
                  state  <= ST_REQ;
               end else if (a_bad) begin
                  mem_err <= 1'b1;
               end else if (a_valid) begin
                  mem_q <= {a_head, a_result, a_canary};
               end
            end
            ST_REQ: begin
               if (dmem.ack) begin
                  mem_q  <= {h_head[HEAD_W-1:1], h_wr, h_wb, h_canary};
                  tcount <= '0;
                  req_q  <= 1'b0;
                  state  <= ST_IDLE;
               end else if (timed_out) begin
                  mem_err <= 1'b1;
                  tcount  <= '0;
                  req_q   <= 1'b0;
                  state   <= ST_IDLE;
               end else begin
                  tcount <= tcount + TW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign dmem.req   = req_q;
   assign dmem.we    = req_q && h_store;
   assign dmem.addr  = {h_addr[DBITS-1:2], 2'b00};
   assign dmem.wdata = al_wdata;
   assign dmem.be    = al_be;

   assign MEM_latch_out     = mem_q;
   assign from_MEM_to_AGEX  = {mem_stall, mem_q[MEM_W-1] & mem_q[WR_BIT],
                               mem_q[RD_LSB +: REG_BITS], mem_q[WB_LSB +: DBITS]};
   assign from_MEM_to_DE    = {mem_q[WR_BIT], mem_q[RD_LSB +: REG_BITS],
                               mem_q[ICNT_LSB +: ICNT_BITS]};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected MEM latches, a
// negedge monitor pops and compares each valid latch the DUT produces.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int DBITS     = 32;
   localparam int AGEX_W    = agex_latch_width(DBITS);
   localparam int MEM_W     = mem_latch_width(DBITS);
   localparam int TO_AGEX_W = to_agex_width(DBITS);
   localparam int TO_DE_W   = TO_DE_WIDTH;

   logic                 clk;
   logic                 rst_n;
   logic [AGEX_W-1:0]    agex_in;
   logic [AGEX_W-1:0]    agex_to;
   logic [MEM_W-1:0]     mem_out;
   logic [MEM_W-1:0]     mem_out_to;
   logic [TO_AGEX_W-1:0] to_agex;
   logic [TO_AGEX_W-1:0] to_agex_to;
   logic [TO_DE_W-1:0]   to_de;
   logic [TO_DE_W-1:0]   to_de_to;
   logic                 mem_err;
   logic                 mem_err_to;

   mem_stage_if #(.DBITS(DBITS)) bus();
   mem_stage_if #(.DBITS(DBITS)) bus_to();

   int compared   = 0;
   int mismatched = 0;
   logic [MEM_W-1:0] exp_q[$];

   mem_stage #(.DBITS(DBITS), .DMEM_TIMEOUT(255)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .from_AGEX_latch   (agex_in),
      .MEM_latch_out     (mem_out),
      .from_MEM_to_AGEX  (to_agex),
      .from_MEM_to_DE    (to_de),
      .dmem              (bus.master),
      .mem_err           (mem_err)
   );

   mem_stage #(.DBITS(DBITS), .DMEM_TIMEOUT(4)) dut_to (
      .clk               (clk),
      .rst_n             (rst_n),
      .from_AGEX_latch   (agex_to),
      .MEM_latch_out     (mem_out_to),
      .from_MEM_to_AGEX  (to_agex_to),
      .from_MEM_to_DE    (to_de_to),
      .dmem              (bus_to.master),
      .mem_err           (mem_err_to)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [AGEX_W-1:0] mk_agex(input logic [OP_BITS-1:0] op, input logic [4:0] rd,
                                                 input logic wr, input logic [31:0] res,
                                                 input logic [31:0] sd, input logic [15:0] icnt);
      return {1'b1, 32'h0000_0013, 32'h0000_0400, op, icnt, rd, wr, res, sd, 4'hA};
   endfunction

   function automatic logic [MEM_W-1:0] mk_mem(input logic [OP_BITS-1:0] op, input logic [4:0] rd,
                                               input logic wr, input logic [31:0] wb,
                                               input logic [15:0] icnt);
      return {1'b1, 32'h0000_0013, 32'h0000_0400, op, icnt, rd, wr, wb, 4'hA};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: every valid MEM latch must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && mem_out[MEM_W-1] === 1'b1) begin
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL unexpected_latch: got 0x%0h, expected no valid latch", mem_out);
            end else begin
               logic [MEM_W-1:0] exp;
               exp = exp_q.pop_front();
               if (mem_out !== exp) begin
                  mismatched++;
                  $display("[TB] FAIL mem_latch: got 0x%0h, expected 0x%0h", mem_out, exp);
               end
            end
         end
      end
   end

   // One memory op on the main DUT, acked after 'delay' unacked REQ cycles.
   task automatic applyStimulus(input string name, input logic [AGEX_W-1:0] a,
                                input logic [MEM_W-1:0] exp, input logic [31:0] rdata,
                                input int delay, input logic [31:0] exp_addr, input logic is_st,
                                input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      int stalls;
      int bubbles;
      stalls  = 0;
      bubbles = 0;
      @(posedge clk);
      #1;
      exp_q.push_back(exp);
      agex_in = a;
      @(negedge clk);
      if (to_agex[TO_AGEX_W-1]) stalls++;
      checkOutput({name, "_req_idle"}, 64'(bus.req), 64'd0);
      @(posedge clk);
      #1;
      agex_in = '0;
      for (int c = 0; c <= delay; c++) begin
         if (c == delay) begin
            bus.ack   = 1'b1;
            bus.rdata = rdata;
         end
         @(negedge clk);
         if (to_agex[TO_AGEX_W-1]) stalls++;
         if (!mem_out[MEM_W-1]) bubbles++;
         checkOutput({name, "_req"}, 64'(bus.req), 64'd1);
         checkOutput({name, "_addr"}, 64'(bus.addr), 64'(exp_addr));
         checkOutput({name, "_we"}, 64'(bus.we), 64'(is_st));
         if (is_st) begin
            checkOutput({name, "_be"}, 64'(bus.be), 64'(exp_be));
            checkOutput({name, "_wdata"}, 64'(bus.wdata), 64'(exp_wdata));
         end
         @(posedge clk);
         #1;
         bus.ack   = 1'b0;
         bus.rdata = '0;
      end
      checkOutput({name, "_stall_cycles"}, 64'(stalls), 64'(delay + 1));
      checkOutput({name, "_bubbles"}, 64'(bubbles), 64'(delay + 1));
      @(negedge clk);
      checkOutput({name, "_valid_out"}, 64'(mem_out[MEM_W-1]), 64'd1);
      checkOutput({name, "_req_done"}, 64'(bus.req), 64'd0);
   endtask

   initial begin
      #200000;
      mismatched++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n        = 1'b0;
      agex_in      = '0;
      agex_to      = '0;
      bus.ack      = 1'b0;
      bus.rdata    = '0;
      bus_to.ack   = 1'b0;
      bus_to.rdata = '0;

      #3;
      checkOutput("rst_latch_zero", 64'(mem_out == '0), 64'd1);
      checkOutput("rst_req", 64'(bus.req), 64'd0);
      checkOutput("rst_stall", 64'(to_agex[TO_AGEX_W-1]), 64'd0);
      checkOutput("rst_err", 64'(mem_err), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ALU op passes through in one cycle with no stall
      @(posedge clk);
      #1;
      agex_in = mk_agex(OP_ADD, 5'd3, 1'b1, 32'h5, 32'h0, 16'd1);
      exp_q.push_back(mk_mem(OP_ADD, 5'd3, 1'b1, 32'h5, 16'd1));
      @(negedge clk);
      checkOutput("add_stall_in", 64'(to_agex[TO_AGEX_W-1]), 64'd0);
      @(posedge clk);
      #1;
      agex_in = '0;
      @(negedge clk);
      checkOutput("add_stall_out", 64'(to_agex[TO_AGEX_W-1]), 64'd0);
      checkOutput("add_fwd_valid", 64'(to_agex[TO_AGEX_W-2]), 64'd1);
      checkOutput("add_fwd_rd", 64'(to_agex[DBITS +: 5]), 64'd3);
      checkOutput("add_fwd_data", 64'(to_agex[DBITS-1:0]), 64'h5);
      checkOutput("add_to_de", 64'(to_de), 64'({1'b1, 5'd3, 16'd1}));

      applyStimulus("lb", mk_agex(OP_LB, 5'd4, 1'b1, 32'h1003, 32'h0, 16'd2),
                    mk_mem(OP_LB, 5'd4, 1'b1, 32'hFFFF_FF80, 16'd2),
                    32'h80FF_FF00, 0, 32'h1000, 1'b0, 4'h0, 32'h0);
      applyStimulus("lbu", mk_agex(OP_LBU, 5'd5, 1'b1, 32'h1003, 32'h0, 16'd3),
                    mk_mem(OP_LBU, 5'd5, 1'b1, 32'h0000_0080, 16'd3),
                    32'h80FF_FF00, 0, 32'h1000, 1'b0, 4'h0, 32'h0);
      applyStimulus("lh", mk_agex(OP_LH, 5'd8, 1'b1, 32'h1002, 32'h0, 16'd4),
                    mk_mem(OP_LH, 5'd8, 1'b1, 32'hFFFF_8001, 16'd4),
                    32'h8001_7FFF, 1, 32'h1000, 1'b0, 4'h0, 32'h0);
      applyStimulus("lhu", mk_agex(OP_LHU, 5'd9, 1'b1, 32'h1000, 32'h0, 16'd5),
                    mk_mem(OP_LHU, 5'd9, 1'b1, 32'h0000_7FFF, 16'd5),
                    32'h8001_7FFF, 0, 32'h1000, 1'b0, 4'h0, 32'h0);
      applyStimulus("sh", mk_agex(OP_SH, 5'd6, 1'b1, 32'h2002, 32'h1234_ABCD, 16'd6),
                    mk_mem(OP_SH, 5'd6, 1'b0, 32'h0, 16'd6),
                    32'h0, 0, 32'h2000, 1'b1, 4'b1100, 32'hABCD_ABCD);
      applyStimulus("sb", mk_agex(OP_SB, 5'd7, 1'b0, 32'h2001, 32'h0000_0077, 16'd7),
                    mk_mem(OP_SB, 5'd7, 1'b0, 32'h0, 16'd7),
                    32'h0, 2, 32'h2000, 1'b1, 4'b0010, 32'h7777_7777);
      applyStimulus("sw", mk_agex(OP_SW, 5'd1, 1'b0, 32'h2004, 32'hCAFE_F00D, 16'd8),
                    mk_mem(OP_SW, 5'd1, 1'b0, 32'h0, 16'd8),
                    32'h0, 0, 32'h2004, 1'b1, 4'b1111, 32'hCAFE_F00D);
      applyStimulus("lw_slow", mk_agex(OP_LW, 5'd10, 1'b1, 32'h3000, 32'h0, 16'd9),
                    mk_mem(OP_LW, 5'd10, 1'b1, 32'hDEAD_BEEF, 16'd9),
                    32'hDEAD_BEEF, 5, 32'h3000, 1'b0, 4'h0, 32'h0);

      // Misaligned LW: no request, bubble, sticky error
      @(posedge clk);
      #1;
      agex_in = mk_agex(OP_LW, 5'd11, 1'b1, 32'h3002, 32'h0, 16'd10);
      @(negedge clk);
      checkOutput("mis_stall", 64'(to_agex[TO_AGEX_W-1]), 64'd0);
      @(posedge clk);
      #1;
      agex_in = '0;
      @(negedge clk);
      checkOutput("mis_valid", 64'(mem_out[MEM_W-1]), 64'd0);
      checkOutput("mis_req", 64'(bus.req), 64'd0);
      checkOutput("mis_err", 64'(mem_err), 64'd1);

      // Stray ack while idle must not produce anything
      @(posedge clk);
      #1;
      bus.ack   = 1'b1;
      bus.rdata = 32'h1111_2222;
      @(negedge clk);
      checkOutput("idle_ack_req", 64'(bus.req), 64'd0);
      @(posedge clk);
      #1;
      bus.ack = 1'b0;
      @(negedge clk);
      checkOutput("idle_ack_valid", 64'(mem_out[MEM_W-1]), 64'd0);

      // ALU op without wr_reg: latch valid but no forwarding; error still sticky
      @(posedge clk);
      #1;
      agex_in = mk_agex(OP_ADD, 5'd7, 1'b0, 32'h77, 32'h0, 16'd11);
      exp_q.push_back(mk_mem(OP_ADD, 5'd7, 1'b0, 32'h77, 16'd11));
      @(posedge clk);
      #1;
      agex_in = '0;
      @(negedge clk);
      checkOutput("add2_fwd_valid", 64'(to_agex[TO_AGEX_W-2]), 64'd0);
      checkOutput("err_sticky", 64'(mem_err), 64'd1);

      // Timeout on the DMEM_TIMEOUT=4 instance
      @(posedge clk);
      #1;
      agex_to = mk_agex(OP_LW, 5'd2, 1'b1, 32'h3000, 32'h0, 16'd12);
      @(negedge clk);
      checkOutput("to_stall", 64'(to_agex_to[TO_AGEX_W-1]), 64'd1);
      @(posedge clk);
      #1;
      agex_to = '0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput("to_req_wait", 64'(bus_to.req), 64'd1);
         checkOutput("to_addr_wait", 64'(bus_to.addr), 64'h3000);
         checkOutput("to_err_wait", 64'(mem_err_to), 64'd0);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      checkOutput("to_err", 64'(mem_err_to), 64'd1);
      checkOutput("to_req_drop", 64'(bus_to.req), 64'd0);
      checkOutput("to_bubble", 64'(mem_out_to[MEM_W-1]), 64'd0);
      checkOutput("to_de_zero", 64'(to_de_to), 64'd0);

      // Reset in the middle of a request, then a late ack
      @(posedge clk);
      #1;
      agex_in = mk_agex(OP_LW, 5'd12, 1'b1, 32'h3000, 32'h0, 16'd13);
      @(posedge clk);
      #1;
      agex_in = '0;
      @(negedge clk);
      checkOutput("rr_req_before", 64'(bus.req), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rr_req", 64'(bus.req), 64'd0);
      checkOutput("rr_latch_zero", 64'(mem_out == '0), 64'd1);
      checkOutput("rr_err", 64'(mem_err), 64'd0);
      checkOutput("rr_stall", 64'(to_agex[TO_AGEX_W-1]), 64'd0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      bus.ack   = 1'b1;
      bus.rdata = 32'h5555_AAAA;
      @(negedge clk);
      checkOutput("rr_late_ack_req", 64'(bus.req), 64'd0);
      @(posedge clk);
      #1;
      bus.ack = 1'b0;
      @(negedge clk);
      checkOutput("rr_late_ack_valid", 64'(mem_out[MEM_W-1]), 64'd0);
      checkOutput("rr_err_after", 64'(mem_err), 64'd0);

      @(posedge clk);
      @(negedge clk);
      checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DBITS, default 32: data and address width.
REQ-002 Parameter DMEM_TIMEOUT, default 255: maximum cycles to wait for dmem_ack.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 from_AGEX_latch  input  AGEX_latch_WIDTH  AGEX latch: {valid, inst, PC, op_I, inst_count, rd, wr_reg, result/address, store_data, bus_canary}.
REQ-006 MEM_latch_out  output  MEM_latch_WIDTH  MEM latch: {valid, inst, PC, op_I, inst_count, rd, wr_reg, wb_data, bus_canary}.
REQ-007 from_MEM_to_AGEX  output  from_MEM_to_AGEX_WIDTH  {mem_stall, fwd_valid, fwd_rd, fwd_data}.
REQ-008 from_MEM_to_DE  output  from_MEM_to_DE_WIDTH  {wr_reg, rd, inst_count} of the current MEM latch, for hazard checks.
REQ-009 dmem_req / dmem_we  output  1 / 1  data-memory request strobe / write qualifier.
REQ-010 dmem_addr, dmem_wdata  output  DBITS each  word-aligned address ({addr[DBITS-1:2],2'b00}); store data lane-replicated.
REQ-011 dmem_be  output  4  byte enables.
REQ-012 dmem_ack / dmem_rdata  input  1 / DBITS  response strobe / aligned read word.
REQ-013 mem_err  output  1  sticky error flag: timeout or misaligned access.

Function
REQ-014 FSM states: IDLE, REQ.
- IDLE with a valid load/store: capture the op into hold registers, assert mem_stall, and enter REQ.
- IDLE with a valid non-memory op: load the MEM latch with wb_data = result in one cycle; mem_stall = 0.
REQ-015 REQ:
- Hold dmem_req=1 and keep addr/we/be/wdata stable until dmem_ack.
- mem_stall = !dmem_ack.
REQ-016 On dmem_ack in REQ:
- Load the MEM latch with the completed op; wb_data = extended load data (stores: 0, wr_reg=0).
- Return to IDLE; mem_stall drops in the same cycle.
- Minimum memory-op latency is 2 cycles.
REQ-017 Whenever mem_stall=1, the MEM latch is loaded with a bubble (all zero).
REQ-018 Loads:
- LB/LBU select the byte addr[1:0]; LH/LHU select the halfword addr[1].
- Signed loads sign-extend to DBITS; unsigned loads zero-extend.
REQ-019 Stores, dmem_be:
- SB: 1<<addr[1:0], byte replicated x4.
- SH: 4'b0011 or 4'b1100 by addr[1], halfword replicated x2.
- SW: 4'b1111.
REQ-020 Misalignment is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- No request is issued; the op becomes a bubble.
- mem_err is set; the FSM stays in IDLE.
REQ-021 Timeout:
- A counter increments each REQ cycle without ack.
- On reaching DMEM_TIMEOUT: set mem_err, drop the op as a bubble, return to IDLE, clear the counter.
REQ-022 dmem_ack while in IDLE is ignored.
REQ-023 Forwarding:
- fwd_valid = MEM latch valid & wr_reg.
- fwd_rd and fwd_data come from the MEM latch (registered, no combinational path from dmem_rdata).
REQ-024 mem_err remains set until reset.

Reset
REQ-025 reset low asynchronously forces:
- state=IDLE, timeout counter=0, hold registers=0, MEM latch=0, mem_err=0.
- dmem_req=0, mem_stall=0.
REQ-026 Reset during REQ abandons the access; a late dmem_ack after reset release is ignored per REQ-022.

Structure
REQ-027 Constants go in define.vh:
- op_I encodings (LB..SW).
- MEM_latch_WIDTH, from_MEM_to_AGEX_WIDTH, from_MEM_to_DE_WIDTH.
- Latch field widths.
REQ-028 The load extractor/sign-extender and store lane/byte-enable generator form one combinational sub-module, mem_align.

Verification
REQ-029 ADD (result=0x5), wr_reg=1, rd=3 -> next cycle MEM latch valid, wb_data=0x5; fwd_rd=3; mem_stall never asserted.
REQ-030 LB addr=0x1003, dmem_rdata=0x80FF_FF00, ack in the 1st REQ cycle -> wb_data=0xFFFF_FF80; LBU same -> 0x0000_0080; total latency 2 cycles.
REQ-031 SH addr=0x2002, store_data=0x1234_ABCD -> dmem_be=4'b1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, dmem_addr=0x2000.
REQ-032 LW addr=0x3000, ack delayed 5 cycles -> mem_stall high for 6 cycles, dmem_req/addr stable throughout, 6 bubbles then the valid load.
REQ-033 LW addr=0x3002 -> no dmem_req, bubble, mem_err=1; no ack with DMEM_TIMEOUT=4 -> mem_err=1 after 4 REQ cycles, return to IDLE.
REQ-034 Reset asserted mid-REQ, then ack after release -> dmem_req=0 immediately, MEM latch zero, ack ignored, mem_err=0.
